// File: rtl/int_ctrl.sv
// int_ctrl: five-source interrupt controller for the SM83 sequencer.
// Latches rising edges of the request lines into IF, masks them with IE,
// resolves priority on acknowledge and serves IF (FF0F) / IE (FFFF).
module int_ctrl (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_irq_in,
  input  logic       i_sel_io,
  input  logic [7:0] i_addr,
  input  logic       i_rd,
  input  logic       i_wr,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_dout_en,
  input  logic       i_int_ack,
  output logic       o_int_req,
  output logic       o_wake,
  output logic [7:0] o_vector
);

  logic [4:0] r_if;
  logic [4:0] r_prev;
  logic [7:0] r_ie;
  logic [7:0] r_vector;
  logic [7:0] r_dout;
  logic       r_dout_en;

  logic [4:0] w_edge;
  logic       w_hit_if;
  logic       w_hit_ie;
  logic [4:0] w_pending;
  logic [4:0] w_ack_mask;
  logic [7:0] w_ack_vec;
  logic [4:0] w_if_base;
  logic [4:0] w_if_next;

  assign w_edge    = i_irq_in & ~r_prev;
  assign w_hit_if  = i_sel_io & (i_addr == 8'h0F);
  assign w_hit_ie  = i_sel_io & (i_addr == 8'hFF);
  assign w_pending = r_if & r_ie[4:0];

  // Priority encode: scan high to low so the lowest pending index wins.
  // With nothing pending the dispatch is cancelled (mask 0, vector 0x00).
  always_comb begin
    w_ack_mask = 5'b00000;
    w_ack_vec  = 8'h00;
    for (int i = 4; i >= 0; i--) begin
      if (w_pending[i]) begin
        w_ack_mask = 5'(1 << i);
        w_ack_vec  = 8'h40 | {2'b00, 3'(i), 3'b000};
      end
    end
  end

  // IF next state: write replaces, acknowledge clears the serviced bit,
  // and a fresh edge overrides both so no request is ever lost.
  always_comb begin
    w_if_base = (i_wr & w_hit_if) ? i_din[4:0] : r_if;
    if (i_int_ack) begin
      w_if_base = w_if_base & ~w_ack_mask;
    end
    w_if_next = w_if_base | w_edge;
  end

  // Request-line history, flag/enable registers and dispatch vector.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prev   <= 5'b00000;
      r_if     <= 5'b00000;
      r_ie     <= 8'h00;
      r_vector <= 8'h00;
    end else begin
      r_prev <= i_irq_in;
      r_if   <= w_if_next;
      if (i_wr & w_hit_ie) begin
        r_ie <= i_din;
      end
      if (i_int_ack) begin
        r_vector <= w_ack_vec;
      end
    end
  end

  // Registered read port; returns pre-write register contents.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dout    <= 8'h00;
      r_dout_en <= 1'b0;
    end else if (i_rd & w_hit_if) begin
      r_dout    <= {3'b111, r_if};
      r_dout_en <= 1'b1;
    end else if (i_rd & w_hit_ie) begin
      r_dout    <= r_ie;
      r_dout_en <= 1'b1;
    end else begin
      r_dout    <= 8'h00;
      r_dout_en <= 1'b0;
    end
  end

  assign o_dout    = r_dout;
  assign o_dout_en = r_dout_en;
  assign o_vector  = r_vector;
  assign o_int_req = |w_pending;
  assign o_wake    = |w_pending;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
module tb_int_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] irq;
  logic       sel;
  logic [7:0] addr;
  logic       rd;
  logic       wr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_en;
  logic       ack;
  logic       int_req;
  logic       wake;
  logic [7:0] vector;

  int total;
  int bad;

  int_ctrl dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_irq_in  (irq),
    .i_sel_io  (sel),
    .i_addr    (addr),
    .i_rd      (rd),
    .i_wr      (wr),
    .i_din     (din),
    .o_dout    (dout),
    .o_dout_en (dout_en),
    .i_int_ack (ack),
    .o_int_req (int_req),
    .o_wake    (wake),
    .o_vector  (vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; din = d; wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a; rd = 1'b1;
    cyc();
    rd = 1'b0;
    chk({tag, "_dout"}, dout, exp);
    chk({tag, "_en"}, {7'd0, dout_en}, 8'h01);
    $display("read  addr=%h dout=%h en=%b", a, dout, dout_en);
  endtask

  task automatic do_ack(input string tag, input logic [7:0] exp_vec, input logic exp_req);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk({tag, "_vec"}, vector, exp_vec);
    chk({tag, "_req"}, {7'd0, int_req}, {7'd0, exp_req});
    $display("ack   vector=%h int_req=%b", vector, int_req);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; irq = 5'd0; sel = 1'b1; addr = 8'h00; rd = 1'b0;
    wr = 1'b0; din = 8'h00; ack = 1'b0;

    // Reset state
    cyc();
    chk("rst_dout", dout, 8'h00);
    chk("rst_en", {7'd0, dout_en}, 8'h00);
    chk("rst_req", {7'd0, int_req}, 8'h00);
    chk("rst_wake", {7'd0, wake}, 8'h00);
    chk("rst_vec", vector, 8'h00);
    rst = 1'b0;
    cyc();

    // Basic request / read / acknowledge on Timer
    do_write(8'hFF, 8'h1F);
    chk("ie_only_req", {7'd0, int_req}, 8'h00);
    irq = 5'b00100;
    cyc();
    irq = 5'd0;
    chk("timer_req", {7'd0, int_req}, 8'h01);
    chk("timer_wake", {7'd0, wake}, 8'h01);
    $display("irq   timer int_req=%b", int_req);
    do_read("timer_if", 8'h0F, 8'hE4);
    cyc();
    chk("idle_en", {7'd0, dout_en}, 8'h00);
    chk("idle_dout", dout, 8'h00);
    do_ack("timer_ack", 8'h50, 1'b0);
    do_read("timer_if_clr", 8'h0F, 8'hE0);

    // Priority
    do_write(8'h0F, 8'h1A);
    chk("prio_req", {7'd0, int_req}, 8'h01);
    do_ack("prio1", 8'h48, 1'b1);
    do_ack("prio2", 8'h58, 1'b1);
    do_ack("prio3", 8'h60, 1'b0);
    cyc();
    chk("vec_hold", vector, 8'h60);

    // Masking
    do_write(8'hFF, 8'h00);
    irq = 5'b00001;
    cyc();
    irq = 5'd0;
    chk("mask_req", {7'd0, int_req}, 8'h00);
    do_read("mask_if", 8'h0F, 8'hE1);
    do_write(8'hFF, 8'h01);
    chk("unmask_req", {7'd0, int_req}, 8'h01);
    do_read("mask_ie", 8'hFF, 8'h01);
    do_write(8'h0F, 8'h00);

    // Collision: write clear vs new edge
    do_write(8'hFF, 8'h1F);
    irq = 5'b01000;
    do_write(8'h0F, 8'h00);
    do_read("coll_wr_if", 8'h0F, 8'hE8);
    irq = 5'd0;
    cyc();

    // Collision: acknowledge vs new edge on the same source
    irq = 5'b01000;
    do_ack("coll_ack", 8'h58, 1'b1);
    irq = 5'd0;
    do_read("coll_ack_if", 8'h0F, 8'hE8);
    do_write(8'h0F, 8'h00);

    // Cancelled dispatch
    do_ack("cancel", 8'h00, 1'b0);
    do_read("cancel_if", 8'h0F, 8'hE0);

    // Level held high sets IF only once
    irq = 5'b10000;
    cyc();
    do_read("level_if", 8'h0F, 8'hF0);
    do_write(8'h0F, 8'h00);
    repeat (6) cyc();
    do_read("level_if_clr", 8'h0F, 8'hE0);
    chk("level_req", {7'd0, int_req}, 8'h00);

    // Asynchronous reset mid-operation
    do_write(8'h0F, 8'h1F);
    do_ack("pre_rst", 8'h40, 1'b1);
    do_read("pre_rst_if", 8'h0F, 8'hFE);
    rd = 1'b1;
    cyc();
    #3;
    rst = 1'b1;
    rd = 1'b0;
    #1;
    chk("arst_dout", dout, 8'h00);
    chk("arst_en", {7'd0, dout_en}, 8'h00);
    chk("arst_req", {7'd0, int_req}, 8'h00);
    chk("arst_wake", {7'd0, wake}, 8'h00);
    chk("arst_vec", vector, 8'h00);
    $display("reset asserted mid-cycle outputs cleared");
    cyc();
    rst = 1'b0;
    // Line still high at first post-reset edge registers an edge.
    cyc();
    do_read("post_rst_if", 8'h0F, 8'hF0);
    do_read("post_rst_ie", 8'hFF, 8'h00);
    chk("post_rst_req", {7'd0, int_req}, 8'h00);
    irq = 5'd0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
